pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 13 +
 rtl/reset_sync2.sv | 20 ++
 rtl/pll_lock_sequencer.sv | 74 +++++++
 tb/tb_pll_lock_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL lock sequencer: FSM encoding and default timing.
package pll_seq_pkg;

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam int unsigned SETTLE_CYCLES_DEF = 16;
    localparam int unsigned HOLD_CYCLES_DEF   = 4;

endpackage

// File: rtl/reset_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clk edge.
module reset_sync2 (
    input  logic clk,
    input  logic arst_n,
    output logic rst_sync_n
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta       <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_sync_n <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences datapath reset release and clock enable after PLL lock, with a halt handshake.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        lock,
    input  logic        halt_req,
    output logic        halt_ack,
    output logic        dp_rst_n,
    output logic        dp_en,
    output logic        ready,
    output logic [31:0] run_cycles,
    output logic [2:0]  dbg_state
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    logic        rst_n;
    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [15:0] settle_cnt;
    logic [7:0]  hold_cnt;

    reset_sync2 u_sync (
        .clk        (clk),
        .arst_n     (lock),
        .rst_sync_n (rst_n)
    );

    // halt_req/halt_ack is a level handshake: halt_req is sampled only in RUN/HALT;
    // halt_ack is high exactly while frozen and follows halt_req with one cycle of latency.
    always_comb begin
        next_state = state;
        case (state)
            S_HOLD:    next_state = S_SETTLE;
            S_SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = S_RELEASE;
            S_RELEASE: if (hold_cnt == HOLD_LAST) next_state = S_RUN;
            S_RUN:     if (halt_req) next_state = S_HALT;
            S_HALT:    if (!halt_req) next_state = S_RUN;
            default:   next_state = S_HOLD;
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HOLD;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            dp_rst_n   <= 1'b0;
            dp_en      <= 1'b0;
            ready      <= 1'b0;
            halt_ack   <= 1'b0;
            run_cycles <= '0;
        end else begin
            state      <= next_state;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 16'd1 : 16'd0;
            hold_cnt   <= (state == S_RELEASE) ? hold_cnt + 8'd1 : 8'd0;
            dp_rst_n   <= (next_state == S_RELEASE) || (next_state == S_RUN) ||
                          (next_state == S_HALT);
            dp_en      <= (next_state == S_RUN);
            ready      <= (next_state == S_RUN) || (next_state == S_HALT);
            halt_ack   <= (next_state == S_HALT);
            if (dp_en) run_cycles <= run_cycles + 32'd1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer; edge 0 is the first clk edge that samples lock high.
module tb_pll_lock_sequencer;

    logic        clk = 1'b0;
    logic        lock = 1'b0;
    logic        halt_req = 1'b0;
    logic        halt_ack, dp_rst_n, dp_en, ready;
    logic [31:0] run_cycles;
    logic [2:0]  dbg_state;
    logic        c_halt_ack, c_dp_rst_n, c_dp_en, c_ready;
    logic [31:0] c_run_cycles;
    logic [2:0]  c_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer dut (
        .clk        (clk),
        .lock       (lock),
        .halt_req   (halt_req),
        .halt_ack   (halt_ack),
        .dp_rst_n   (dp_rst_n),
        .dp_en      (dp_en),
        .ready      (ready),
        .run_cycles (run_cycles),
        .dbg_state  (dbg_state)
    );

    pll_lock_sequencer #(.SETTLE_CYCLES(1), .HOLD_CYCLES(1)) dut_min (
        .clk        (clk),
        .lock       (lock),
        .halt_req   (halt_req),
        .halt_ack   (c_halt_ack),
        .dp_rst_n   (c_dp_rst_n),
        .dp_en      (c_dp_en),
        .ready      (c_ready),
        .run_cycles (c_run_cycles),
        .dbg_state  (c_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold lock low for a few cycles, then raise it at a negedge.
    task automatic start_seq();
        @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        lock = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " outs"}, {28'd0, dp_rst_n, dp_en, ready, halt_ack}, 32'd0);
        check({tag, " run_cycles"}, run_cycles, 32'd0);
        check({tag, " state"}, {29'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset min outs", {28'd0, c_dp_rst_n, c_dp_en, c_ready, c_halt_ack}, 32'd0);

        // Power-up with defaults and with the minimum-parameter instance
        lock = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            check($sformatf("pwr e%0d", e), {28'd0, dp_rst_n, dp_en, ready, halt_ack},
                  {28'd0, 1'(e >= 18), 1'(e >= 22), 1'(e >= 22), 1'b0});
            check($sformatf("pwr min e%0d", e), {28'd0, c_dp_rst_n, c_dp_en, c_ready, c_halt_ack},
                  {28'd0, 1'(e >= 3), 1'(e >= 4), 1'(e >= 4), 1'b0});
            if (e == 1 || e == 2)
                check($sformatf("pwr state e%0d", e), {29'd0, dbg_state}, (e == 1) ? 32'd0 : 32'd1);
        end
        check("pwr run_cycles", run_cycles, 32'd8);
        check("pwr min run_cycles", c_run_cycles, 32'd26);

        // Halt handshake: 10 cycles of halt_req
        halt_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("halt en/ack c%0d", i), {30'd0, dp_en, halt_ack}, 32'd1);
            check($sformatf("halt run_cycles c%0d", i), run_cycles, 32'd9);
        end
        halt_req = 1'b0;
        tick();
        check("resume en/ack", {30'd0, dp_en, halt_ack}, 32'd2);
        check("resume run_cycles", run_cycles, 32'd9);
        tick();
        check("resume run_cycles+1", run_cycles, 32'd10);

        // Lock loss while halted clears everything asynchronously
        halt_req = 1'b1;
        tick();
        check("halt2 state", {29'd0, dbg_state}, 32'd4);
        #2 lock = 1'b0;
        #1 check_all_zero("loss in halt");

        // Early halt: halt_req already high through the whole sequence
        start_seq();
        for (int e = 0; e <= 21; e++) begin
            tick();
            check($sformatf("early e%0d", e), {30'd0, dp_en, halt_ack}, 32'd0);
        end
        tick();
        check("early run", {29'd0, dp_en, ready, halt_ack}, 32'b110);
        tick();
        check("early halt", {29'd0, dp_en, ready, halt_ack}, 32'b011);
        check("early run_cycles", run_cycles, 32'd1);
        repeat (2) tick();
        check("early run_cycles held", run_cycles, 32'd1);
        check("early min run_cycles", c_run_cycles, 32'd1);

        // Lock lost at SETTLE count 8, then a full restart
        halt_req = 1'b0;
        start_seq();
        for (int e = 0; e <= 10; e++) tick();
        check("mid state", {29'd0, dbg_state}, 32'd1);
        check("mid settle_cnt", {16'd0, dut.settle_cnt}, 32'd8);
        #2 lock = 1'b0;
        #1 check_all_zero("mid loss");
        start_seq();
        for (int e = 0; e <= 25; e++) begin
            tick();
            check($sformatf("restart e%0d", e), {30'd0, dp_rst_n, dp_en},
                  {30'd0, 1'(e >= 18), 1'(e >= 22)});
        end
        check("restart run_cycles", run_cycles, 32'd3);

        // run_cycles wraps
        force dut.run_cycles = 32'hFFFF_FFFE;
        #1 release dut.run_cycles;
        tick();
        check("wrap 1", run_cycles, 32'hFFFF_FFFF);
        tick();
        check("wrap 2", run_cycles, 32'h0000_0000);
        tick();
        check("wrap 3", run_cycles, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
